// File: rtl/exwb_stage.sv
// Execute-to-writeback stage: a small FIFO of {rd, result} entries feeding the
// register file, plus the architectural status flags and a retired-result counter.
module exwb_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [3:0]       ex_op,
  input  logic [2:0]       ex_rd,
  input  logic [7:0]       ex_result,
  input  logic [2:0]       ex_flags,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [2:0]       wb_rd,
  output logic [7:0]       wb_data,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic [CNT_W-1:0] retired
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic               bubble, accept, push, drain;

  // Bubbles are consumed like any other result but leave no trace.
  assign bubble   = (ex_op == 4'b0000) || (ex_op == 4'b1110);
  assign ex_ready = (occ != FULL_OCC);
  assign accept   = ex_valid && ex_ready;
  assign push     = accept && !bubble;
  assign wb_valid = (occ != '0);
  assign drain    = wb_valid && wb_ready;
  assign head     = mem[rd_ptr];

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (wb_valid) begin
      wb_rd   = head.rd;
      wb_data = head.data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_v  <= 1'b0;
      retired <= '0;
    end else begin
      case ({push, drain})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        flag_n <= ex_flags[2];
        flag_z <= ex_flags[1];
        flag_v <= ex_flags[0];
      end
      if (drain) begin
        rd_ptr  <= rd_ptr + 1'b1;
        retired <= retired + 1'b1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy gates it off
  // the outputs, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: ex_rd, data: ex_result};
  end

endmodule

// File: doc/exwb_stage.md
EXWB_STAGE -- requirements
Module: exwb_stage

Interface
REQ-001 Parameter DEPTH, default 2, number of result-buffer entries (power of two, >= 2).
REQ-002 Parameter CNT_W, default 8, width of the retired-result counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ex_valid  input  1  execute stage presents a result this cycle.
REQ-006 ex_ready  output  1  stage can accept a result this cycle.
REQ-007 ex_op  input  4  opcode that produced the result.
REQ-008 ex_rd  input  3  destination register index.
REQ-009 ex_result  input  8  ALU result R.
REQ-010 ex_flags  input  3  ALU flags {neg, zero, overflow}, bit 2 = neg.
REQ-011 wb_valid  output  1  writeback entry available.
REQ-012 wb_ready  input  1  register file consumes the entry this cycle.
REQ-013 wb_rd  output  3  writeback register index.
REQ-014 wb_data  output  8  writeback data.
REQ-015 flag_n, flag_z, flag_v  output  1 each  architectural status flags.
REQ-016 retired  output  CNT_W  count of completed writebacks.

Function
REQ-017 Accept = ex_valid && ex_ready; Drain = wb_valid && wb_ready.
REQ-018 ex_ready SHALL be 1 when buffer occupancy < DEPTH, 0 when full; combinational from registered occupancy only (no path from wb_ready).
REQ-019 Buffer is FIFO: entries leave in acceptance order; wb_valid = occupancy != 0; wb_rd/wb_data SHALL show the head entry, 0 when empty.
REQ-020 Bubble opcodes 4'b0000 and 4'b1110 SHALL be accepted (ex_ready honoured) but not enqueued and SHALL NOT change flags.
REQ-021 Non-bubble accept SHALL enqueue {ex_rd, ex_result}; entry visible on wb_* the cycle after accept (1-cycle latency minimum).
REQ-022 Non-bubble accept SHALL load flag_n/flag_z/flag_v from ex_flags[2]/[1]/[0], visible next cycle.
REQ-023 Flags SHALL hold value between non-bubble accepts, independent of drain.
REQ-024 Simultaneous Accept and Drain: occupancy unchanged, head advances, new entry appended; allowed at any occupancy where ex_ready=1.
REQ-025 Full with wb_ready=1: entry drains, ex_ready stays 0 that cycle, rises next cycle.
REQ-026 wb_* SHALL stay stable while wb_valid=1 and wb_ready=0.
REQ-027 retired SHALL increment by 1 per Drain, wrapping from 2^CNT_W-1 to 0.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; no entry lost or duplicated at wrap.
REQ-029 wb_ready while empty SHALL have no effect.

Reset
REQ-030 rst_n low SHALL immediately clear occupancy, pointers, flags and retired to 0; wb_valid=0, wb_rd=0, wb_data=0, ex_ready=1.
REQ-031 Reset mid-operation SHALL discard all buffered entries; no writeback issued after release until a new accept.
REQ-032 First accept permitted on the first rising edge with rst_n high.

Verification
REQ-033 Reset then accept op=1000 rd=3 R=8'h5A flags=3'b000 -> next cycle wb_valid=1, wb_rd=3, wb_data=8'h5A; flags 000.
REQ-034 wb_ready=0, accept R=8'h01,8'h02 -> ex_ready=0; third ex_valid ignored; wb_ready=1 -> 8'h01 then 8'h02 drained, retired=2.
REQ-035 Accept op=1001 R=8'h00 flags=3'b010, then op=0000 flags=3'b101 -> flag_z=1, flag_n=0, flag_v=0 hold; only one wb entry.
REQ-036 Occupancy 1, Accept and Drain same cycle for 10 cycles with R=0..9 -> wb_data sequence 0..9 in order, occupancy stays 1.
REQ-037 Force 256 drains with CNT_W=8 -> retired wraps to 0; 257th drain -> 1.
REQ-038 Two entries buffered, pulse rst_n low mid-cycle -> wb_valid=0 and flags=0 at once, ex_ready=1, no stale writeback after release.
